// File: rtl/bnn_unpool2d_stream.sv
// Binary nearest-neighbour upsampler: one pooled multi-channel map in, one upsampled row per beat out.
// Optional macro BNN_UNPOOL_BACK2BACK_EN lets the next frame load on the last-beat handshake (no bubble).
module bnn_unpool2d_stream #(
  parameter int NUM_CHANNELS = 3,
  parameter int IMG_WIDTH    = 28,
  parameter int IMG_HEIGHT   = 28,
  parameter int POOL_SIZE    = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_CHANNELS*(IMG_WIDTH/POOL_SIZE)*(IMG_HEIGHT/POOL_SIZE)-1:0] in_feature,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [IMG_WIDTH-1:0]                      out_row,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] out_chan,
  output logic [$clog2(IMG_HEIGHT)-1:0]             out_row_idx,
  output logic                                      out_last
);

  localparam int IN_W  = IMG_WIDTH / POOL_SIZE;
  localparam int IN_H  = IMG_HEIGHT / POOL_SIZE;
  localparam int PLANE = IN_W * IN_H;
  localparam int TOTAL = NUM_CHANNELS * PLANE;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t             state_q, state_d;
  logic [TOTAL-1:0]   fbuf_q, fbuf_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [IMG_WIDTH-1:0] row_pix;
  logic               last_beat;
  logic               in_fire;
  logic               out_fire;

  assign last_beat = (ch_q == CH_W'(NUM_CHANNELS - 1)) && (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

`ifdef BNN_UNPOOL_BACK2BACK_EN
  assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_STREAM) && last_beat && out_ready));
`else
  assign in_ready = !rst && (state_q == S_IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_fire) state_d = S_STREAM;
      // A frame accepted on the last-beat handshake keeps us streaming.
      S_STREAM: if (out_fire && last_beat && !in_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fbuf_d = fbuf_q;
    ch_d   = ch_q;
    row_d  = row_q;
    if (in_fire) begin
      fbuf_d = in_feature;
      ch_d   = '0;
      row_d  = '0;
    end else if (out_fire) begin
      if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
        row_d = '0;
        ch_d  = ch_q + CH_W'(1);
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fbuf_q <= '0;
      ch_q   <= '0;
      row_q  <= '0;
    end else begin
      fbuf_q <= fbuf_d;
      ch_q   <= ch_d;
      row_q  <= row_d;
    end
  end

  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    row_pix = '0;
    for (int c = 0; c < IMG_WIDTH; c++) begin
      idx = IDX_W'(ch_q) * IDX_W'(PLANE)
          + IDX_W'(int'(row_q) / POOL_SIZE) * IDX_W'(IN_W)
          + IDX_W'(c / POOL_SIZE);
      row_pix[c] = fbuf_q[idx];
    end
  end

  always_comb begin
    out_valid   = (state_q == S_STREAM);
    out_row     = out_valid ? row_pix : '0;
    out_chan    = out_valid ? ch_q : '0;
    out_row_idx = out_valid ? row_q : '0;
    out_last    = out_valid && last_beat;
  end

endmodule

// File: tb/tb_bnn_unpool2d_stream.sv
// Directed + randomized checks of bnn_unpool2d_stream against a pixel-map reference model.
module tb_bnn_unpool2d_stream;

  localparam int C     = 2;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int P     = 2;
  localparam int IW    = W / P;
  localparam int IH    = H / P;
  localparam int FB    = C * IW * IH;
  localparam int BEATS = C * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FB-1:0] in_feature = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_row;
  logic [0:0]    out_chan;
  logic [1:0]    out_row_idx;
  logic          out_last;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bnn_unpool2d_stream #(
    .NUM_CHANNELS(C), .IMG_WIDTH(W), .IMG_HEIGHT(H), .POOL_SIZE(P)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feature(in_feature),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_chan(out_chan), .out_row_idx(out_row_idx), .out_last(out_last)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Unpack the frame into a channel/y/x pixel map, then replicate each pixel PxP.
  function automatic logic [W-1:0] ref_row(input logic [FB-1:0] f, input int ch, input int r);
    logic         pix [C][IH][IW];
    logic [W-1:0] row;
    int           k;
    k = 0;
    for (int cc = 0; cc < C; cc++)
      for (int y = 0; y < IH; y++)
        for (int x = 0; x < IW; x++) begin
          pix[cc][y][x] = f[k];
          k++;
        end
    row = '0;
    for (int x = 0; x < W; x++) row[x] = pix[ch][r / P][x / P];
    return row;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [FB-1:0] f, input int k);
    chk({tag, "_vld"},  32'(out_valid), 32'(1));
    chk({tag, "_row"},  32'(out_row), 32'(ref_row(f, k / H, k % H)));
    chk({tag, "_chan"}, 32'(out_chan), 32'(k / H));
    chk({tag, "_ridx"}, 32'(out_row_idx), 32'(k % H));
    chk({tag, "_last"}, 32'(out_last), 32'(k == BEATS - 1));
  endtask

  task automatic run_frame(input logic [FB-1:0] f, input int stall_beat, input int stall_len,
                           input bit disturb, input string tag);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'(1));
    in_valid   = 1'b1;
    in_feature = f;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      check_beat($sformatf("%s_b%0d", tag, k), f, k);
      if (k == stall_beat && stall_len > 0) begin
        out_ready = 1'b0;
        #1;
        chk({tag, "_stall_inrdy"}, 32'(in_ready), 32'(0));
        repeat (stall_len) begin
          tick();
          check_beat($sformatf("%s_hold%0d", tag, k), f, k);
        end
        out_ready = 1'b1;
      end
      if (disturb && k < BEATS - 1) begin
        in_valid   = (k % 2 == 0);
        in_feature = FB'($urandom);
        #1;
        chk($sformatf("%s_inrdy%0d", tag, k), 32'(in_ready), 32'(0));
      end
      tick();
      in_valid = 1'b0;
    end
    chk({tag, "_end_vld"}, 32'(out_valid), 32'(0));
    chk({tag, "_end_inrdy"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    logic [FB-1:0] fa;
    logic [FB-1:0] fb;
    logic [FB-1:0] fcur;
    int            got;
    bit            b_sent;
    bit            fire;
    bit            exp_vld;

    // Reset state
    repeat (3) tick();
    chk("rst_inrdy", 32'(in_ready), 32'(0));
    chk("rst_vld",   32'(out_valid), 32'(0));
    chk("rst_row",   32'(out_row), 32'(0));
    chk("rst_chan",  32'(out_chan), 32'(0));
    chk("rst_ridx",  32'(out_row_idx), 32'(0));
    chk("rst_last",  32'(out_last), 32'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_inrdy", 32'(in_ready), 32'(1));
    chk("post_rst_vld",   32'(out_valid), 32'(0));

    // Directed frames
    run_frame(8'h01, -1, 0, 1'b0, "f01");
    run_frame(8'h80, -1, 0, 1'b0, "f80");
    run_frame(8'hFF, 2, 5, 1'b0, "fFF_stall");

    // Two frames offered continuously
    fa = FB'($urandom);
    fb = FB'($urandom);
    got = 0;
    b_sent = 1'b0;
    in_valid = 1'b1;
    in_feature = fa;
    for (int t = 0; t <= 18; t++) begin
`ifdef BNN_UNPOOL_BACK2BACK_EN
      exp_vld = (t >= 1 && t <= 16);
`else
      exp_vld = (t >= 1 && t <= 8) || (t >= 10 && t <= 17);
`endif
      if (t > 0) chk($sformatf("b2b_vld_t%0d", t), 32'(out_valid), 32'(exp_vld));
      if (out_valid && got < 2 * BEATS) begin
        fcur = (got < BEATS) ? fa : fb;
        chk($sformatf("b2b_row%0d", got), 32'(out_row), 32'(ref_row(fcur, (got % BEATS) / H, got % H)));
        chk($sformatf("b2b_last%0d", got), 32'(out_last), 32'((got % BEATS) == BEATS - 1));
        got++;
      end
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        if (!b_sent) begin
          in_feature = fb;
          b_sent = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b_beats", 32'(got), 32'(2 * BEATS));

    // Reset pulse mid-frame
    in_valid = 1'b1;
    in_feature = 8'hFF;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check_beat("mid_pre", 8'hFF, 4);
    rst = 1'b1;
    #1;
    chk("mid_rst_inrdy", 32'(in_ready), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("mid_post_vld",   32'(out_valid), 32'(0));
    chk("mid_post_inrdy", 32'(in_ready), 32'(1));
    chk("mid_post_row",   32'(out_row), 32'(0));
    chk("mid_post_last",  32'(out_last), 32'(0));
    run_frame(8'h02, -1, 0, 1'b0, "f02");

    // in_valid toggled while streaming must be ignored
    run_frame(8'h5A, -1, 0, 1'b1, "disturb");

    // Randomized frames with random stalls
    for (int i = 0; i < 8; i++)
      run_frame(FB'($urandom), $urandom_range(0, BEATS - 1), $urandom_range(0, 3), 1'b0,
                $sformatf("rnd%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bnn_unpool2d_stream.md
# bnn_unpool2d_stream

Streaming binary nearest-neighbour upsampler (unpooling): the inverse direction of the team's binary 2D max-pool stage. Accepts one flattened multi-channel pooled feature map per valid/ready transaction. Emits the upsampled image one row per beat, channel-major, on a valid/ready output stream. Sits between a pooled BNN layer and a row-serial consumer, such as a decoder/reconstruction layer or an external row writer.

## Interface
- NUM_CHANNELS, 3, channels in and out
- IMG_WIDTH, 28, output image width (pixels)
- IMG_HEIGHT, 28, output image height (rows)
- POOL_SIZE, 2, upsample factor in each dimension; IMG_WIDTH and IMG_HEIGHT are integer multiples of it
- IN_W, IMG_WIDTH/POOL_SIZE, input map width (derived)
- IN_H, IMG_HEIGHT/POOL_SIZE, input map height (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame
- in_feature  in  NUM_CHANNELS*IN_W*IN_H  flattened pooled map; bit index = ch*IN_W*IN_H + row*IN_W + col
- out_valid  out  1  out_row valid
- out_ready  in  1  downstream accepts the beat
- out_row  out  IMG_WIDTH  one output row; out_row[c] = pixel at column c
- out_chan  out  max(1,$clog2(NUM_CHANNELS))  channel of current beat
- out_row_idx  out  $clog2(IMG_HEIGHT)  row of current beat
- out_last  out  1  final beat of frame (last channel, last row)

## Operation
- FSM states: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: register in_feature into the frame buffer, clear the channel and row counters, go to STREAM.
- STREAM:
  - out_valid=1.
  - out_row[c] = buf[ch*IN_W*IN_H + (r/POOL_SIZE)*IN_W + c/POOL_SIZE], with ch = out_chan and r = out_row_idx.
  - On out_valid && out_ready: row++. When row reaches IMG_HEIGHT-1, wrap to 0 and increment ch.
  - On the handshake of the beat with out_last=1, return to IDLE (see Configuration for back-to-back behaviour).
- Beat order: ch0 rows 0..H-1, then ch1, and so on. Total beats per frame = NUM_CHANNELS*IMG_HEIGHT.
- The frame buffer is written only on an input handshake and is held stable for the whole frame.
- When out_valid=0, out_row, out_chan, out_row_idx and out_last are driven to 0.
- Division and modulo are by the constant POOL_SIZE. Index arithmetic is sized to $clog2 of the full vector width; no truncation is permitted.

## Timing
- Reset values: state IDLE, counters 0, out_valid=0, out_row=0, out_chan=0, out_row_idx=0, out_last=0. in_ready=0 while rst=1 and 1 in the first cycle after reset.
- Latency: input handshake at cycle N → first beat valid at N+1.
- Throughput: one row per cycle when out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, all out_* signals hold stable and the counters hold.
- in_valid while in STREAM: ignored (in_ready=0), except as allowed by the Configuration macro.
- Reset asserted mid-frame: the frame is aborted and the remaining beats are discarded. Next cycle after deassertion, outputs are at reset values and the block is in IDLE.
- out_valid never drops without a handshake once asserted, except under reset.

## Configuration
- BNN_UNPOOL_BACK2BACK_EN defined:
  - In STREAM, in_ready = out_last && out_ready.
  - A frame accepted in the same cycle as the last-beat handshake reloads the buffer and counters and stays in STREAM. The next frame's first beat follows in the next cycle, with zero bubble.
- BNN_UNPOOL_BACK2BACK_EN undefined:
  - in_ready=0 throughout STREAM.
  - Exactly one idle cycle (IDLE, out_valid=0) between frames, minimum.

## Test plan
Configuration used: NUM_CHANNELS=2, IMG_WIDTH=IMG_HEIGHT=4, POOL_SIZE=2, giving an 8-bit input.
- in_feature=8'h01, out_ready=1 → 8 beats. ch0 rows 0,1 = 4'b0011; ch0 rows 2,3 = 0; ch1 all 0; out_last only on beat 8 (ch1, row 3).
- in_feature=8'h80 → ch1 rows 2,3 = 4'b1100; all other beats 0.
- in_feature=8'hFF with out_ready low 5 cycles on beat 3 → beat 3 (ch0, row 2, 4'b1111) held stable for 5 cycles, then the remaining beats complete; 8 handshakes total.
- Two frames presented continuously with out_ready=1 → without the macro, beats in cycles 1–8 and 10–17 (one bubble at 9); with BNN_UNPOOL_BACK2BACK_EN, cycles 1–16 with no bubble.
- rst pulsed for 1 cycle after beat 4 → next cycle out_valid=0, in_ready=1. A new frame 8'h02 then yields ch0 rows 0,1 = 4'b1100 on its first two beats.
- in_valid toggled during STREAM (macro off) → no input handshake, buffer unchanged, output sequence identical to the undisturbed run.
